clarke_foc: RTL and testbench
=============================

CLARKE_FOC -- requirements
Module: clarke_foc

Interface
REQ-001 Parameter g_STD_IO_WIDTH, default 18, sets the width of all data ports (two's-complement signed; theta is unsigned).
REQ-002 Port sys_clk_i, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 Port reset_i, input, 1 bit: reset, asynchronous and active-low.
REQ-004 Port start_i, input, 1 bit: request to begin one transform, sampled on the rising edge.
REQ-005 Port ia_i, input, W bits, signed: phase-A current sample.
REQ-006 Port ib_i, input, W bits, signed: phase-B current sample.
REQ-007 Port theta_i, input, W bits: rotor angle (full scale 2^W = 360 deg), captured with the currents.
REQ-008 Port busy_o, output, 1 bit: high while a transform is in progress.
REQ-009 Port done_o, output, 1 bit: one-cycle pulse when the outputs update; connects directly to the downstream CORDIC start_i.
REQ-010 Port alpha_o, output, W bits, signed: Clarke alpha component.
REQ-011 Port beta_o, output, W bits, signed: Clarke beta component.
REQ-012 Port theta_o, output, W bits: the captured theta_i, aligned with alpha_o and beta_o.

Function
REQ-013 The block SHALL compute alpha = ia and beta = (ia + 2*ib)/sqrt(3), using constant K = 151349 (0x24F35 = round(2^18/sqrt(3))).
REQ-014 The state machine SHALL have three states: IDLE, MUL and OUT; encodings not in use SHALL return to IDLE.
REQ-015 In IDLE, on an edge where start_i=1, the block SHALL:
- capture ia_i, ib_i and theta_i;
- form sum = ia + 2*ib at W+2 bits signed;
- store sign(sum) and |sum| at W+1 bits unsigned;
- clear the accumulator and the bit counter, and enter MUL.
REQ-016 MUL SHALL last exactly 18 cycles, one per bit of K (counter 0..17), processed LSB first.
- Each cycle, add (|sum| << counter) to a 37-bit accumulator when K[counter] = 1.
- Move to OUT after counter = 17.
REQ-017 In OUT, the block SHALL form the result and then return to IDLE:
- mag = accumulator >> 18 (truncation toward zero);
- beta = -mag if the stored sign is negative, else mag;
- saturate beta symmetrically to +/-(2^(W-1) - 1).
REQ-018 On the OUT-state edge, the block SHALL register alpha_o = captured ia, beta_o = saturated beta and theta_o = captured theta, and set done_o = 1 for exactly one cycle.
REQ-019 Latency: if start_i is sampled at edge E0, then done_o and the new outputs SHALL become valid after edge E19.
REQ-020 busy_o SHALL be 1 after edges E0..E18 and 0 once done_o is asserted.
REQ-021 start_i SHALL be ignored in MUL and OUT (no queuing), so the minimum start-to-start spacing is 20 cycles.
REQ-022 alpha_o, beta_o and theta_o SHALL hold their values between done_o pulses.
REQ-023 Inputs ia_i, ib_i and theta_i SHALL be sampled only at the accepted start edge; later changes SHALL NOT affect the result in progress.

Reset
REQ-024 While reset_i = 0, the block SHALL immediately force:
- state = IDLE;
- busy_o = 0 and done_o = 0;
- alpha_o, beta_o and theta_o = 0;
- accumulator, counter and the captured registers = 0.
REQ-025 A reset asserted mid-operation SHALL abort the transform with no done_o pulse; the first start_i after reset_i returns high SHALL be accepted.

Verification
REQ-026 ia=0, ib=0, theta=0x1234, start pulse at E0 -> done_o pulses after E19 with alpha=0, beta=0, theta_o=0x1234; busy_o high for 19 cycles.
REQ-027 ia=1000, ib=0 -> alpha=1000, beta=577. Then ia=-1000, ib=-1000 -> alpha=-1000, beta=-1732.
REQ-028 Saturation cases:
- ia=131071, ib=131071 (sum 393213) -> beta=131071;
- ia=-131072, ib=-131072 -> alpha=-131072, beta=-131071.
REQ-029 start_i held high continuously -> exactly one transform per 20 cycles; inputs changed during MUL do not alter the result.
REQ-030 reset_i pulsed low at E10 of a transform -> outputs zero immediately, no done_o pulse; a new start afterwards completes normally with 19-cycle latency.

Source files
------------

// File: rtl/clarke_foc.sv
// Clarke transform front end for FOC: alpha = ia, beta = (ia + 2*ib)/sqrt(3).
// beta uses an 18-cycle LSB-first shift-and-add multiply by round(2^18/sqrt(3)).
module clarke_foc #(
    parameter int g_STD_IO_WIDTH = 18
) (
    input  logic                             sys_clk_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic signed [g_STD_IO_WIDTH-1:0] ia_i,
    input  logic signed [g_STD_IO_WIDTH-1:0] ib_i,
    input  logic        [g_STD_IO_WIDTH-1:0] theta_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic signed [g_STD_IO_WIDTH-1:0] alpha_o,
    output logic signed [g_STD_IO_WIDTH-1:0] beta_o,
    output logic        [g_STD_IO_WIDTH-1:0] theta_o
);

    localparam int W     = g_STD_IO_WIDTH;
    localparam int K_W   = 18;
    localparam int ACC_W = W + 19;
    localparam logic [K_W-1:0] K_INV_SQRT3 = 18'h24F35;
    localparam logic [W:0]     MAX_MAG     = {2'b00, {(W-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic signed [W-1:0]  ia_q, ia_d;
    logic        [W-1:0]  theta_q, theta_d;
    logic                 sign_q, sign_d;
    logic        [W:0]    mag_q, mag_d;
    logic        [ACC_W-1:0] acc_q, acc_d;
    logic        [4:0]    cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic signed [W-1:0]  alpha_q, alpha_d;
    logic signed [W-1:0]  beta_q, beta_d;
    logic        [W-1:0]  theta_out_q, theta_out_d;

    logic signed [W+1:0]  ia_ext, ib_x2, sum, sum_neg;
    logic        [ACC_W-1:0] addend;
    logic        [W:0]    prod_mag, sat_mag;

    // Sum is formed at W+2 bits so ia + 2*ib can never overflow.
    assign ia_ext  = {{2{ia_i[W-1]}}, ia_i};
    assign ib_x2   = {ib_i[W-1], ib_i, 1'b0};
    assign sum     = ia_ext + ib_x2;
    assign sum_neg = -sum;

    assign addend   = {{(ACC_W-W-1){1'b0}}, mag_q} << cnt_q;
    assign prod_mag = acc_q[ACC_W-1:K_W];
    assign sat_mag  = (prod_mag > MAX_MAG) ? MAX_MAG : prod_mag;

    always_comb begin
        state_d     = state_q;
        ia_d        = ia_q;
        theta_d     = theta_q;
        sign_d      = sign_q;
        mag_d       = mag_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        alpha_d     = alpha_q;
        beta_d      = beta_q;
        theta_out_d = theta_out_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    ia_d    = ia_i;
                    theta_d = theta_i;
                    sign_d  = sum[W+1];
                    mag_d   = sum[W+1] ? sum_neg[W:0] : sum[W:0];
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_MUL;
                end
            end
            S_MUL: begin
                if (K_INV_SQRT3[cnt_q]) begin
                    acc_d = acc_q + addend;
                end
                if (cnt_q == 5'd17) begin
                    state_d = S_OUT;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_OUT: begin
                alpha_d     = ia_q;
                beta_d      = sign_q ? -$signed(sat_mag[W-1:0]) : $signed(sat_mag[W-1:0]);
                theta_out_d = theta_q;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            ia_q        <= '0;
            theta_q     <= '0;
            sign_q      <= 1'b0;
            mag_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            alpha_q     <= '0;
            beta_q      <= '0;
            theta_out_q <= '0;
        end else begin
            state_q     <= state_d;
            ia_q        <= ia_d;
            theta_q     <= theta_d;
            sign_q      <= sign_d;
            mag_q       <= mag_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            alpha_q     <= alpha_d;
            beta_q      <= beta_d;
            theta_out_q <= theta_out_d;
        end
    end

    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign alpha_o = alpha_q;
    assign beta_o  = beta_q;
    assign theta_o = theta_out_q;

endmodule

// File: tb/tb_clarke_foc.sv
// Self-checking bench for clarke_foc: directed vector table plus
// back-to-back start, input-change and mid-transform reset sequences.
module tb_clarke_foc;

    localparam int W = 18;

    logic                sys_clk_i = 1'b0;
    logic                reset_i   = 1'b0;
    logic                start_i   = 1'b0;
    logic signed [W-1:0] ia_i      = '0;
    logic signed [W-1:0] ib_i      = '0;
    logic        [W-1:0] theta_i   = '0;
    logic                busy_o, done_o;
    logic signed [W-1:0] alpha_o, beta_o;
    logic        [W-1:0] theta_o;

    int errors = 0;
    int checks = 0;

    clarke_foc #(.g_STD_IO_WIDTH(W)) dut (
        .sys_clk_i (sys_clk_i),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .ia_i      (ia_i),
        .ib_i      (ib_i),
        .theta_i   (theta_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .alpha_o   (alpha_o),
        .beta_o    (beta_o),
        .theta_o   (theta_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    typedef struct {
        int ia;
        int ib;
        int theta;
        int exp_alpha;
        int exp_beta;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Launches one transform, scrambles the inputs right after the start edge,
    // and returns the number of edges until done_o is seen (-1 on timeout).
    task automatic do_xfer(input int a, input int b, input int th, output int lat);
        bit busy_ok;
        @(negedge sys_clk_i);
        start_i = 1'b1;
        ia_i    = W'(a);
        ib_i    = W'(b);
        theta_i = W'(th);
        @(posedge sys_clk_i);
        #1;
        start_i = 1'b0;
        ia_i    = ~W'(a);
        ib_i    = ~W'(b);
        theta_i = ~W'(th);
        busy_ok = 1'b1;
        lat     = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge sys_clk_i);
            #1;
            if (done_o) begin
                lat = k;
                break;
            end
            if (!busy_o) busy_ok = 1'b0;
        end
        check("busy_during", longint'(busy_ok), 1);
        check("busy_at_done", longint'(busy_o), 0);
    endtask

    initial begin
        int lat;
        int done_cnt;
        int first_at, second_at;

        vecs[0]  = '{0,       0,       'h1234, 0,       0};
        vecs[1]  = '{1000,    0,       'h0001, 1000,    577};
        vecs[2]  = '{-1000,   -1000,   'h3FFFF, -1000,  -1732};
        vecs[3]  = '{131071,  131071,  'h2AAAA, 131071, 131071};
        vecs[4]  = '{-131072, -131072, 'h15555, -131072, -131071};
        vecs[5]  = '{1,       0,       'h00010, 1,       0};
        vecs[6]  = '{-1,      0,       'h00020, -1,      0};
        vecs[7]  = '{0,       1,       'h00030, 0,       1};
        vecs[8]  = '{100,     -50,     'h00040, 100,     0};
        vecs[9]  = '{3,       0,       'h00050, 3,       1};
        vecs[10] = '{0,       -1000,   'h00060, 0,       -1154};

        #1;
        check("rst_busy",  longint'(busy_o), 0);
        check("rst_done",  longint'(done_o), 0);
        check("rst_alpha", longint'(alpha_o), 0);
        check("rst_beta",  longint'(beta_o), 0);
        check("rst_theta", longint'(theta_o), 0);
        repeat (2) @(negedge sys_clk_i);
        reset_i = 1'b1;

        foreach (vecs[i]) begin
            do_xfer(vecs[i].ia, vecs[i].ib, vecs[i].theta, lat);
            check($sformatf("v%0d_latency", i), longint'(lat), 19);
            check($sformatf("v%0d_alpha", i), longint'(alpha_o), longint'(vecs[i].exp_alpha));
            check($sformatf("v%0d_beta", i),  longint'(beta_o),  longint'(vecs[i].exp_beta));
            check($sformatf("v%0d_theta", i), longint'(theta_o), longint'(vecs[i].theta));
            @(posedge sys_clk_i);
            #1;
            check($sformatf("v%0d_done_1cyc", i), longint'(done_o), 0);
            check($sformatf("v%0d_hold_beta", i), longint'(beta_o), longint'(vecs[i].exp_beta));
        end

        // start held high: one transform per 20 cycles, mid-MUL input changes ignored
        @(negedge sys_clk_i);
        start_i = 1'b1;
        ia_i = 18'sd1000;
        ib_i = 18'sd0;
        theta_i = 18'h00ABC;
        @(posedge sys_clk_i);
        #1;
        ia_i = -18'sd5;
        ib_i = 18'sd7;
        theta_i = 18'h00DEF;
        done_cnt = 0;
        first_at = -1;
        second_at = -1;
        for (int k = 1; k <= 45; k++) begin
            @(posedge sys_clk_i);
            #1;
            if (done_o) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    first_at = k;
                    check("hold_first_alpha", longint'(alpha_o), 1000);
                    check("hold_first_beta",  longint'(beta_o), 577);
                    check("hold_first_theta", longint'(theta_o), 'h00ABC);
                end else if (done_cnt == 2) begin
                    second_at = k;
                    start_i = 1'b0;
                    check("hold_second_alpha", longint'(alpha_o), -5);
                    check("hold_second_beta",  longint'(beta_o), 5);
                    check("hold_second_theta", longint'(theta_o), 'h00DEF);
                end
            end
        end
        start_i = 1'b0;
        check("hold_first_at",  longint'(first_at), 19);
        check("hold_second_at", longint'(second_at), 39);
        check("hold_done_count", longint'(done_cnt), 2);

        // reset mid-transform: immediate clear, no done, clean restart
        @(negedge sys_clk_i);
        start_i = 1'b1;
        ia_i = 18'sd2000;
        ib_i = 18'sd0;
        theta_i = 18'h01111;
        @(posedge sys_clk_i);
        #1;
        start_i = 1'b0;
        repeat (10) @(posedge sys_clk_i);
        #1;
        reset_i = 1'b0;
        #1;
        check("abort_busy",  longint'(busy_o), 0);
        check("abort_done",  longint'(done_o), 0);
        check("abort_alpha", longint'(alpha_o), 0);
        check("abort_beta",  longint'(beta_o), 0);
        check("abort_theta", longint'(theta_o), 0);
        repeat (2) @(negedge sys_clk_i);
        reset_i = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge sys_clk_i);
            #1;
            if (done_o) done_cnt++;
        end
        check("abort_no_done", longint'(done_cnt), 0);

        do_xfer(-1000, -1000, 'h02222, lat);
        check("restart_latency", longint'(lat), 19);
        check("restart_alpha", longint'(alpha_o), -1000);
        check("restart_beta",  longint'(beta_o), -1732);
        check("restart_theta", longint'(theta_o), 'h02222);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
